// File: rtl/replay_pkg.sv
// Shared definitions for the replay frame path: FSM encoding, sizing helper and
// the controller frame width also used by serial_handler and n64_controller.
package replay_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Index width that stays at least one bit wide for a single console.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above the
// pointer, wrapping to the lowest requesting index overall.
module rr_arbiter
    import replay_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = clog2_min1(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [CW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [CW-1:0] o_idx,
    output logic          o_valid
);

    logic          w_found;
    logic [CW-1:0] w_idx;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_req[i] && (i >= int'(i_ptr))) begin
                w_found = 1'b1;
                w_idx   = CW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_req[i]) begin
                w_found = 1'b1;
                w_idx   = CW'(i);
            end
        end
    end

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < N; i++) begin
            o_grant[i] = w_found && (int'(w_idx) == i);
        end
    end

    assign o_idx   = w_idx;
    assign o_valid = w_found;

endmodule

// File: rtl/replay_frame_router.sv
// Distributes serial frames to per-console queues in lockstep or round-robin.
// Optional REPLAY_ROUTER_TIMEOUT_EN abandons and requeues unanswered requests.
module replay_frame_router
    import replay_pkg::*;
#(
    parameter int  NUM_CONSOLES   = 4,
    parameter int  DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int  TIMEOUT_CYCLES = 2_500_000,
    localparam int CW             = clog2_min1(NUM_CONSOLES)
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic [NUM_CONSOLES-1:0] console_request,
    input  logic                    mode_set_valid,
    input  logic [NUM_CONSOLES-1:0] mode_set_value,
    input  logic                    mode_toggle,
    input  logic                    sync_mode,
    output logic                    upstream_request,
    output logic [CW-1:0]           upstream_console,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    input  logic [DATA_WIDTH-1:0]   frame_data,
    output logic [NUM_CONSOLES-1:0] console_wr_en,
    output logic [DATA_WIDTH-1:0]   console_data,
    output logic [NUM_CONSOLES-1:0] input_mode,
    output logic [7:0]              timeout_count,
    output logic [1:0]              dbg_state,
    output logic [NUM_CONSOLES-1:0] dbg_pending
);

    // Frame handshake: a word transfers on a cycle where frame_valid and
    // frame_ready are both high; frame_ready is high only while waiting for it.

    state_t r_state, w_next_state;

    logic [NUM_CONSOLES-1:0] r_mode, r_pending, r_target_mask, r_wr_en;
    logic [CW-1:0]           r_target_idx, r_ptr;
    logic [DATA_WIDTH-1:0]   r_data;

    logic [NUM_CONSOLES-1:0] w_active, w_req_vec, w_rr_grant, w_clr, w_requeue, w_pend_next;
    logic [CW-1:0]           w_rr_idx;
    logic                    w_rr_valid, w_lock_hit, w_idle_ok, w_grant_fire, w_accept, w_timeout;

    assign w_active   = r_mode;
    assign w_req_vec  = r_pending & w_active;
    assign w_lock_hit = (|w_active) && (w_req_vec == w_active);
    // The write cycle itself makes no new grant, spacing requests after a write.
    assign w_idle_ok    = (r_state == ST_IDLE) && (r_wr_en == '0);
    assign w_grant_fire = w_idle_ok && (sync_mode ? w_lock_hit : w_rr_valid);
    assign w_accept     = (r_state == ST_WAIT) && frame_valid;

    rr_arbiter #(
        .N  (NUM_CONSOLES),
        .CW (CW)
    ) u_rr_arbiter (
        .i_req   (w_req_vec),
        .i_ptr   (r_ptr),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_valid (w_rr_valid)
    );

`ifdef REPLAY_ROUTER_TIMEOUT_EN
    logic [31:0] r_wait_cnt;
    logic [7:0]  r_timeout_count;

    assign w_timeout = (r_state == ST_WAIT) && !frame_valid
                       && (r_wait_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_wait_cnt      <= '0;
            r_timeout_count <= '0;
        end else begin
            r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + 32'd1 : '0;
            if (w_timeout && (r_timeout_count != 8'hff)) begin
                r_timeout_count <= r_timeout_count + 8'd1;
            end
        end
    end

    assign timeout_count = r_timeout_count;
`else
    assign w_timeout     = 1'b0;
    assign timeout_count = 8'd0;
`endif

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_grant_fire) w_next_state = ST_REQ;
            ST_REQ:  w_next_state = ST_WAIT;
            ST_WAIT: if (w_accept || w_timeout) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        upstream_request = (r_state == ST_REQ);
        frame_ready      = (r_state == ST_WAIT);
    end

    always_comb begin
        w_clr = '0;
        if (w_grant_fire) begin
            w_clr = sync_mode ? w_active : w_rr_grant;
        end
        w_requeue   = w_timeout ? r_target_mask : '0;
        // Passthrough consoles never hold a pending request.
        w_pend_next = ((r_pending & ~w_clr) | console_request | w_requeue) & r_mode;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_mode        <= '1;
            r_pending     <= '0;
            r_target_mask <= '0;
            r_target_idx  <= '0;
            r_ptr         <= '0;
            r_wr_en       <= '0;
            r_data        <= '0;
        end else begin
            if (mode_set_valid) begin
                r_mode <= mode_set_value;
            end else if (mode_toggle) begin
                r_mode <= ~r_mode;
            end
            r_pending <= w_pend_next;
            if (w_grant_fire) begin
                if (sync_mode) begin
                    r_target_mask <= w_active;
                    r_target_idx  <= '0;
                end else begin
                    r_target_mask <= w_rr_grant;
                    r_target_idx  <= w_rr_idx;
                    r_ptr <= (int'(w_rr_idx) == NUM_CONSOLES - 1) ? '0 : w_rr_idx + CW'(1);
                end
            end
            r_wr_en <= w_accept ? r_target_mask : '0;
            if (w_accept) begin
                r_data <= frame_data;
            end
        end
    end

    assign upstream_console = r_target_idx;
    assign console_wr_en    = r_wr_en;
    assign console_data     = r_data;
    assign input_mode       = r_mode;
    assign dbg_state        = r_state;
    assign dbg_pending      = r_pending;

endmodule

// File: tb/tb_replay_frame_router.sv
// Directed bench for replay_frame_router: lockstep, round-robin, mode changes,
// backpressure, reset mid-wait and (with REPLAY_ROUTER_TIMEOUT_EN) timeout.
module tb_replay_frame_router;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  console_request = '0;
    logic          mode_set_valid = 1'b0;
    logic [N-1:0]  mode_set_value = '0;
    logic          mode_toggle = 1'b0;
    logic          sync_mode = 1'b1;
    logic          upstream_request;
    logic [1:0]    upstream_console;
    logic          frame_valid = 1'b0;
    logic          frame_ready;
    logic [DW-1:0] frame_data = '0;
    logic [N-1:0]  console_wr_en;
    logic [DW-1:0] console_data;
    logic [N-1:0]  input_mode;
    logic [7:0]    timeout_count;
    logic [1:0]    dbg_state;
    logic [N-1:0]  dbg_pending;

    int checks = 0;
    int failures = 0;
    int n_upreq = 0;

    replay_frame_router #(
        .NUM_CONSOLES   (N),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .sys_clk          (sys_clk),
        .reset            (reset),
        .console_request  (console_request),
        .mode_set_valid   (mode_set_valid),
        .mode_set_value   (mode_set_value),
        .mode_toggle      (mode_toggle),
        .sync_mode        (sync_mode),
        .upstream_request (upstream_request),
        .upstream_console (upstream_console),
        .frame_valid      (frame_valid),
        .frame_ready      (frame_ready),
        .frame_data       (frame_data),
        .console_wr_en    (console_wr_en),
        .console_data     (console_data),
        .input_mode       (input_mode),
        .timeout_count    (timeout_count),
        .dbg_state        (dbg_state),
        .dbg_pending      (dbg_pending)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (upstream_request) n_upreq++;
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        step(2);
        reset = 1'b0;
        check("rst_mode", input_mode, 4'hf);
        check("rst_upreq", upstream_request, 0);
        check("rst_ready", frame_ready, 0);
        check("rst_wr_en", console_wr_en, 0);
        check("rst_console", upstream_console, 0);
        check("rst_data", console_data, 0);
        check("rst_tocnt", timeout_count, 0);
        check("rst_pending", dbg_pending, 0);
        check("rst_state", dbg_state, 0);

        // Lockstep: staggered requests from all four consoles
        n_upreq = 0;
        sync_mode = 1'b1;
        for (int i = 0; i < N; i++) begin
            console_request = N'(1 << i);
            step();
        end
        console_request = '0;
        check("lk_pending_full", dbg_pending, 4'hf);
        check("lk_no_req_yet", upstream_request, 0);
        step();
        check("lk_upreq", upstream_request, 1);
        check("lk_console", upstream_console, 0);
        check("lk_pending_clr", dbg_pending, 0);
        step();
        check("lk_ready", frame_ready, 1);
        frame_valid = 1'b1;
        frame_data = 32'h12345678;
        step();
        frame_valid = 1'b0;
        check("lk_wr_en", console_wr_en, 4'b1111);
        check("lk_data", console_data, 32'h12345678);
        check("lk_idle", dbg_state, 0);
        step();
        check("lk_wr_done", console_wr_en, 0);
        check("lk_one_upreq", n_upreq, 1);

        // Independent: consoles 1 and 3 together, pointer at 0
        sync_mode = 1'b0;
        console_request = 4'b1010;
        step();
        console_request = '0;
        step();
        check("rr_upreq1", upstream_request, 1);
        check("rr_console1", upstream_console, 1);
        check("rr_pending1", dbg_pending, 4'b1000);
        step();
        frame_valid = 1'b1;
        frame_data = 32'hA1A1A1A1;
        step();
        frame_valid = 1'b0;
        check("rr_wr1", console_wr_en, 4'b0010);
        check("rr_data1", console_data, 32'hA1A1A1A1);
        step();
        check("rr_gap", upstream_request, 0);
        step();
        check("rr_upreq2", upstream_request, 1);
        check("rr_console2", upstream_console, 3);
        step();
        frame_valid = 1'b1;
        frame_data = 32'hB2B2B2B2;
        step();
        frame_valid = 1'b0;
        check("rr_wr2", console_wr_en, 4'b1000);
        check("rr_data2", console_data, 32'hB2B2B2B2);

        // Mode interaction: consoles 0 and 2 in TAS, console 1 passthrough
        sync_mode = 1'b1;
        mode_set_valid = 1'b1;
        mode_set_value = 4'b0101;
        step();
        mode_set_valid = 1'b0;
        check("md_mode", input_mode, 4'b0101);
        console_request = 4'b0111;
        step();
        console_request = '0;
        check("md_pending", dbg_pending, 4'b0101);
        step();
        check("md_upreq", upstream_request, 1);
        step();
        mode_toggle = 1'b1;
        step();
        mode_toggle = 1'b0;
        check("md_toggled", input_mode, 4'b1010);
        check("md_still_wait", dbg_state, 2);
        frame_valid = 1'b1;
        frame_data = 32'hC3C3C3C3;
        step();
        frame_valid = 1'b0;
        check("md_wr_frozen", console_wr_en, 4'b0101);
        mode_set_valid = 1'b1;
        mode_set_value = 4'b1111;
        step();
        mode_set_valid = 1'b0;

        // Backpressure: frame_valid held in IDLE
        frame_valid = 1'b1;
        frame_data = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_ready", frame_ready, 0);
            check("bp_no_wr", console_wr_en, 0);
        end
        console_request = 4'b1111;
        step();
        console_request = '0;
        check("bp_no_wr_pend", console_wr_en, 0);
        step();
        check("bp_req_ready", frame_ready, 0);
        step();
        check("bp_wait_ready", frame_ready, 1);
        step();
        frame_valid = 1'b0;
        check("bp_wr", console_wr_en, 4'b1111);
        check("bp_data", console_data, 32'hDEADBEEF);
        step();

        // Reset during WAIT discards the frame
        mode_set_valid = 1'b1;
        mode_set_value = 4'b0011;
        step();
        mode_set_valid = 1'b0;
        console_request = 4'b0011;
        step();
        console_request = '0;
        step(2);
        check("rs_in_wait", dbg_state, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rs_mode", input_mode, 4'hf);
        check("rs_pending", dbg_pending, 0);
        check("rs_state", dbg_state, 0);
        frame_valid = 1'b1;
        frame_data = 32'h55AA55AA;
        step();
        check("rs_no_wr1", console_wr_en, 0);
        check("rs_ready", frame_ready, 0);
        step();
        check("rs_no_wr2", console_wr_en, 0);
        frame_valid = 1'b0;

        // Unanswered request in independent mode
        sync_mode = 1'b0;
        console_request = 4'b0001;
        step();
        console_request = '0;
        step(2);
        check("to_enter_wait", dbg_state, 2);
        step(99);
`ifdef REPLAY_ROUTER_TIMEOUT_EN
        check("to_wait_100", dbg_state, 2);
        step();
        check("to_idle", dbg_state, 0);
        check("to_count", timeout_count, 1);
        check("to_requeue", dbg_pending, 4'b0001);
        step();
        check("to_reissue", upstream_request, 1);
        step();
`else
        step(50);
        check("to_hold_wait", dbg_state, 2);
        check("to_count_tied", timeout_count, 0);
`endif
        frame_valid = 1'b1;
        frame_data = 32'h0F0F0F0F;
        step();
        frame_valid = 1'b0;
        check("to_late_wr", console_wr_en, 4'b0001);
        check("to_late_data", console_data, 32'h0F0F0F0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
